// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, latencies and FSM encoding.
package md_defs;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6
  } md_op_e;

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] MULT_CYCLES = 4'd5;
  localparam logic [CNT_W-1:0] DIV_CYCLES  = 4'd10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the E stage and the multiply/divide unit.
interface mult_div_unit_if;
  logic        start;
  logic [3:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        cancel;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output start, op, A, B, cancel, input busy, HI, LO);
  modport slave  (input start, op, A, B, cancel, output busy, HI, LO);
endinterface

// File: rtl/mult_div_unit_latency_counter.sv
// Down-counter that models the multi-cycle latency; done marks the last busy cycle.
module md_latency_counter
  import md_defs::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             done_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == CNT_W'(1));

endmodule

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit: result computed at accept, committed after a fixed latency.
// state   | meaning
// IDLE    | accepting requests; MTHI/MTLO write HI/LO directly
// RUN     | MULT/DIV in flight, busy=1, pending result waits for done
module mult_div_unit
  import md_defs::*;
(
  input  logic            clk,
  input  logic            reset_n,
  mult_div_unit_if.slave  md
);

  md_state_e   state_q;
  logic        busy_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] pend_hi_q, pend_lo_q;
  logic        pend_wr_q;

  md_op_e      op_e;
  logic        accept;
  logic        is_long;
  logic        is_mult;
  logic        cnt_done;

  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag;
  logic [31:0] div_n, div_d;
  logic [31:0] div_q, div_r;
  logic [31:0] res_hi, res_lo;
  logic        res_wr;

  assign op_e    = md_op_e'(md.op);
  assign accept  = md.start && !md.cancel && (state_q == ST_IDLE);
  assign is_mult = (op_e == MD_MULT) || (op_e == MD_MULTU);
  assign is_long = is_mult || (op_e == MD_DIV) || (op_e == MD_DIVU);

  md_latency_counter u_cnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (accept && is_long),
    .load_val_i (is_mult ? MULT_CYCLES : DIV_CYCLES),
    .done_o     (cnt_done)
  );

  assign prod_s = $signed({{32{md.A[31]}}, md.A}) * $signed({{32{md.B[31]}}, md.B});
  assign prod_u = {32'd0, md.A} * {32'd0, md.B};

  // One shared divider: signed division runs on magnitudes and fixes signs afterwards.
  assign a_mag = md.A[31] ? neg32(md.A) : md.A;
  assign b_mag = md.B[31] ? neg32(md.B) : md.B;
  assign div_n = (op_e == MD_DIV) ? a_mag : md.A;
  assign div_d = (md.B == '0) ? 32'd1 : ((op_e == MD_DIV) ? b_mag : md.B);
  assign div_q = div_n / div_d;
  assign div_r = div_n % div_d;

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    res_wr = 1'b0;
    case (op_e)
      MD_MULT: begin
        {res_hi, res_lo} = prod_s;
        res_wr = 1'b1;
      end
      MD_MULTU: begin
        {res_hi, res_lo} = prod_u;
        res_wr = 1'b1;
      end
      MD_DIV: begin
        res_lo = (md.A[31] ^ md.B[31]) ? neg32(div_q) : div_q;
        res_hi = md.A[31] ? neg32(div_r) : div_r;
        res_wr = (md.B != '0);
      end
      MD_DIVU: begin
        res_lo = div_q;
        res_hi = div_r;
        res_wr = (md.B != '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            case (op_e)
              MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                state_q   <= ST_RUN;
                busy_q    <= 1'b1;
                pend_hi_q <= res_hi;
                pend_lo_q <= res_lo;
                pend_wr_q <= res_wr;
              end
              MD_MTHI: hi_q <= md.A;
              MD_MTLO: lo_q <= md.A;
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          if (cnt_done) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            if (pend_wr_q) begin
              hi_q <= pend_hi_q;
              lo_q <= pend_lo_q;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign md.busy = busy_q;
  assign md.HI   = hi_q;
  assign md.LO   = lo_q;

endmodule
